// File: rtl/dcmac_0_stats_pkg.sv
// Shared definitions for the DCMAC TX statistics poller: FSM state encoding,
// APB read-address field layout and the snapshot record format.
package dcmac_0_stats_pkg;

    localparam int ID_W        = 6;
    localparam int IDX_W       = 5;
    localparam int ID_LSB      = 16;
    localparam int IDX_LSB     = 8;
    localparam int HI_BIT      = 0;
    localparam int DEF_NUM_CNT = 26;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP_LO  = 3'd1,
        ST_ACCESS_LO = 3'd2,
        ST_SETUP_HI  = 3'd3,
        ST_ACCESS_HI = 3'd4,
        ST_PUSH      = 3'd5
    } poll_state_e;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [IDX_W-1:0] index;
        logic [63:0]      data;
        logic             err;
        logic             last;
    } snap_rec_t;

    // Counter read address: channel id, counter index and half select; all else 0
    function automatic logic [31:0] mk_paddr(input logic [ID_W-1:0]  id,
                                             input logic [IDX_W-1:0] idx,
                                             input logic             hi);
        logic [31:0] a;
        a = '0;
        a[ID_LSB +: ID_W]   = id;
        a[IDX_LSB +: IDX_W] = idx;
        a[HI_BIT]           = hi;
        return a;
    endfunction

endpackage

// File: rtl/dcmac_0_stats_req_arb.sv
// Round-robin channel arbiter for the TX stats poller. Searches the pending
// bitmap starting one past the last granted channel; pointer moves on take.
module dcmac_0_stats_req_arb
    import dcmac_0_stats_pkg::*;
#(
    parameter int NUM_CH = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] i_pend,
    input  logic              i_take,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [ID_W-1:0]   o_gnt_id,
    output logic              o_gnt_vld
);

    logic [ID_W-1:0] ptr_q, ptr_d;

    // First pending channel strictly after ptr_q, wrapping at NUM_CH
    always_comb begin
        int c;
        c         = 0;
        o_gnt     = '0;
        o_gnt_id  = '0;
        o_gnt_vld = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            c = int'(ptr_q) + i;
            if (c >= NUM_CH) c = c - NUM_CH;
            if (!o_gnt_vld && i_pend[ID_W'(c)]) begin
                o_gnt_vld          = 1'b1;
                o_gnt[ID_W'(c)]    = 1'b1;
                o_gnt_id           = ID_W'(c);
            end
        end
    end

    // Remember the channel just granted so it goes to the back of the line
    always_comb begin
        ptr_d = ptr_q;
        if (i_take && o_gnt_vld) ptr_d = o_gnt_id;
    end

    // Pointer resets to the last channel so channel 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= ID_W'(NUM_CH - 1);
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/dcmac_0_tx_stats_poller.sv
// APB3 master draining the DCMAC TX statistics counter bank. Each requested
// channel is swept counter by counter (low then high 32-bit read) and every
// counter is emitted as one 64-bit record on a ready/valid stream.
// Optional build macro DCMAC_TX_STATS_POLL_TIMEOUT_EN adds an access-phase
// watchdog that aborts a read after TIMEOUT cycles without pready.
module dcmac_0_tx_stats_poller
    import dcmac_0_stats_pkg::*;
#(
    parameter int NUM_CH  = 40,
    parameter int NUM_CNT = DEF_NUM_CNT,
    parameter int TIMEOUT = 255
) (
    input  logic              apb3_clk,
    input  logic              apb3_rstn,
    input  logic [NUM_CH-1:0] i_poll_req,
    output logic [31:0]       APB_S_paddr,
    output logic              APB_S_psel,
    output logic              APB_S_penable,
    output logic              APB_S_pwrite,
    output logic [31:0]       APB_S_pwdata,
    input  logic [31:0]       APB_S_prdata,
    input  logic              APB_S_pready,
    input  logic              APB_S_pslverr,
    output logic              o_snap_valid,
    input  logic              i_snap_ready,
    output logic [5:0]        o_snap_id,
    output logic [4:0]        o_snap_index,
    output logic [63:0]       o_snap_data,
    output logic              o_snap_err,
    output logic              o_snap_last,
    output logic              o_busy
);

    poll_state_e       state_q, state_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [31:0]       paddr_q, paddr_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    snap_rec_t         rec_q, rec_d;

    logic [NUM_CH-1:0] gnt;
    logic [ID_W-1:0]   gnt_id;
    logic              gnt_vld;
    logic              take;
    logic              xfer_done;
    logic [31:0]       rd_data;
    logic              rd_err;

    assign take = (state_q == ST_IDLE);

    dcmac_0_stats_req_arb #(.NUM_CH(NUM_CH)) u_arb (
        .clk       (apb3_clk),
        .rst_n     (apb3_rstn),
        .i_pend    (pend_q),
        .i_take    (take),
        .o_gnt     (gnt),
        .o_gnt_id  (gnt_id),
        .o_gnt_vld (gnt_vld)
    );

`ifdef DCMAC_TX_STATS_POLL_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_hit;

    // Watchdog reloads in SETUP and counts down through ACCESS
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == ST_SETUP_LO || state_q == ST_SETUP_HI)
            tmo_d = TMO_W'(TIMEOUT);
        else if ((state_q == ST_ACCESS_LO || state_q == ST_ACCESS_HI) && tmo_q != '0)
            tmo_d = tmo_q - 1'b1;
    end

    // Watchdog register
    always_ff @(posedge apb3_clk or negedge apb3_rstn) begin
        if (!apb3_rstn) tmo_q <= '0;
        else            tmo_q <= tmo_d;
    end

    // Last allowed access cycle without pready: end the read as a zero error
    assign tmo_hit   = (tmo_q <= TMO_W'(1)) && !APB_S_pready;
    assign xfer_done = APB_S_pready || tmo_hit;
    assign rd_data   = tmo_hit ? 32'd0 : APB_S_prdata;
    assign rd_err    = tmo_hit || APB_S_pslverr;
`else
    assign xfer_done = APB_S_pready;
    assign rd_data   = APB_S_prdata;
    assign rd_err    = APB_S_pslverr;
`endif

    // Sweep FSM: grant, two APB reads per counter, then hold the record
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q | i_poll_req;
        paddr_d   = paddr_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        rec_d     = rec_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    // a request landing this same cycle re-pends its channel
                    pend_d      = (pend_q & ~gnt) | i_poll_req;
                    state_d     = ST_SETUP_LO;
                    rec_d.id    = gnt_id;
                    rec_d.index = '0;
                    rec_d.err   = 1'b0;
                    rec_d.last  = 1'b0;
                    busy_d      = 1'b1;
                    paddr_d     = mk_paddr(gnt_id, '0, 1'b0);
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                end
            end
            ST_SETUP_LO: begin
                state_d   = ST_ACCESS_LO;
                penable_d = 1'b1;
            end
            ST_ACCESS_LO: begin
                if (xfer_done) begin
                    rec_d.data[31:0] = rd_data;
                    rec_d.err        = rec_q.err | rd_err;
                    state_d          = ST_SETUP_HI;
                    paddr_d[HI_BIT]  = 1'b1;
                    penable_d        = 1'b0;
                end
            end
            ST_SETUP_HI: begin
                state_d   = ST_ACCESS_HI;
                penable_d = 1'b1;
            end
            ST_ACCESS_HI: begin
                if (xfer_done) begin
                    rec_d.data[63:32] = rd_data;
                    rec_d.err         = rec_q.err | rd_err;
                    rec_d.last        = (rec_q.index == IDX_W'(NUM_CNT - 1));
                    state_d           = ST_PUSH;
                    psel_d            = 1'b0;
                    penable_d         = 1'b0;
                    valid_d           = 1'b1;
                end
            end
            ST_PUSH: begin
                if (i_snap_ready) begin
                    valid_d    = 1'b0;
                    rec_d.err  = 1'b0;
                    rec_d.last = 1'b0;
                    if (rec_q.last) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        rec_d.index = rec_q.index + 1'b1;
                        paddr_d     = mk_paddr(rec_q.id, rec_q.index + 1'b1, 1'b0);
                        psel_d      = 1'b1;
                        state_d     = ST_SETUP_LO;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset discards any partial record
    always_ff @(posedge apb3_clk or negedge apb3_rstn) begin
        if (!apb3_rstn) begin
            state_q   <= ST_IDLE;
            pend_q    <= '0;
            paddr_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            rec_q     <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            paddr_q   <= paddr_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            rec_q     <= rec_d;
        end
    end

    assign APB_S_paddr   = paddr_q;
    assign APB_S_psel    = psel_q;
    assign APB_S_penable = penable_q;
    assign APB_S_pwrite  = 1'b0;
    assign APB_S_pwdata  = 32'd0;
    assign o_snap_valid  = valid_q;
    assign o_snap_id     = rec_q.id;
    assign o_snap_index  = rec_q.index;
    assign o_snap_data   = rec_q.data;
    assign o_snap_err    = rec_q.err;
    assign o_snap_last   = rec_q.last;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_dcmac_0_tx_stats_poller.sv
// Directed bench for dcmac_0_tx_stats_poller: behavioural APB slave returning
// {index, half}, a record collector and per-scenario tasks with inline checks.
module tb_dcmac_0_tx_stats_poller;
    import dcmac_0_stats_pkg::*;

    localparam int NUM_CH  = 40;
    localparam int NUM_CNT = 26;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NUM_CH-1:0] poll_req = '0;
    logic [31:0]       paddr;
    logic              psel, penable, pwrite;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready, pslverr;
    logic              snap_valid;
    logic              snap_ready = 1'b1;
    logic [5:0]        snap_id;
    logic [4:0]        snap_index;
    logic [63:0]       snap_data;
    logic              snap_err, snap_last, busy;

    int errors = 0;
    int checks = 0;

    // slave configuration
    int hi_wait   = 0;
    bit err_en    = 0;
    int err_idx   = 0;
    bit stall_en  = 0;
    int stall_idx = 0;
    int acc_cnt   = 0;

    always #5 clk = ~clk;

    dcmac_0_tx_stats_poller #(.NUM_CH(NUM_CH), .NUM_CNT(NUM_CNT), .TIMEOUT(TIMEOUT)) dut (
        .apb3_clk      (clk),
        .apb3_rstn     (rstn),
        .i_poll_req    (poll_req),
        .APB_S_paddr   (paddr),
        .APB_S_psel    (psel),
        .APB_S_penable (penable),
        .APB_S_pwrite  (pwrite),
        .APB_S_pwdata  (pwdata),
        .APB_S_prdata  (prdata),
        .APB_S_pready  (pready),
        .APB_S_pslverr (pslverr),
        .o_snap_valid  (snap_valid),
        .i_snap_ready  (snap_ready),
        .o_snap_id     (snap_id),
        .o_snap_index  (snap_index),
        .o_snap_data   (snap_data),
        .o_snap_err    (snap_err),
        .o_snap_last   (snap_last),
        .o_busy        (busy)
    );

    // APB slave: wait states count access cycles spent without pready
    always @(posedge clk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end

    logic [4:0] s_idx;
    logic       s_hi;
    assign s_idx = paddr[12:8];
    assign s_hi  = paddr[0];

    always_comb begin
        pready = 1'b0;
        if (psel && penable) begin
            pready = (acc_cnt >= (s_hi ? hi_wait : 0));
            if (stall_en && !s_hi && int'(s_idx) == stall_idx) pready = 1'b0;
        end
        pslverr = pready && err_en && !s_hi && int'(s_idx) == err_idx;
        prdata  = {26'd0, s_idx, s_hi};
    end

    // Collector / protocol monitor, sampled on the falling edge
    snap_rec_t   recs[$];
    snap_rec_t   cur, hold_ref;
    int          busy_cycles = 0, addr_viol = 0, hold_viol = 0, hold_cnt = 0, lo2_cnt = 0;
    bit          hold_en = 0;
    int          hold_idx = 0;
    logic        prev_psel = 1'b0;
    logic [31:0] prev_paddr = '0;

    always @(negedge clk) begin
        cur = {snap_id, snap_index, snap_data, snap_err, snap_last};
        if (rstn) begin
            if (busy) busy_cycles++;
            if (psel && penable && (!prev_psel || paddr !== prev_paddr)) addr_viol++;
            if (psel && penable && !paddr[0] && paddr[12:8] == 5'd2) lo2_cnt++;
            snap_ready = 1'b1;
            if (hold_en && snap_valid && int'(snap_index) == hold_idx) begin
                if (hold_cnt == 0) hold_ref = cur;
                else if (cur !== hold_ref || psel || penable) hold_viol++;
                if (hold_cnt < 4) begin
                    snap_ready = 1'b0;
                    hold_cnt++;
                end
            end
            if (snap_valid && snap_ready) recs.push_back(cur);
        end
        prev_psel  = psel;
        prev_paddr = paddr;
    end

    task automatic pulse(input logic [NUM_CH-1:0] m);
        @(negedge clk); poll_req = m;
        @(negedge clk); poll_req = '0;
    endtask

    // Bounded wait for n records and the poller going idle again
    task automatic wait_recs(input int n, input int limit, input string tag);
        int k;
        k = 0;
        while ((recs.size() < n || busy) && k < limit) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= limit) begin
            errors++;
            $display("FAIL %s_wait: timed out with %0d records busy=%0b, need %0d", tag, recs.size(), busy, n);
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({psel, penable, snap_valid, busy} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl: psel/penable/valid/busy=%b expected 0000", {psel, penable, snap_valid, busy});
        end
        checks++;
        if (paddr !== 32'd0) begin
            errors++; $display("FAIL reset_paddr: got %h expected 0", paddr);
        end
        checks++;
        if ({snap_id, snap_index, snap_data, snap_err, snap_last} !== 77'd0) begin
            errors++; $display("FAIL reset_rec: id=%0d idx=%0d data=%h err=%b last=%b expected all 0", snap_id, snap_index, snap_data, snap_err, snap_last);
        end
        checks++;
        if (pwrite !== 1'b0 || pwdata !== 32'd0) begin
            errors++; $display("FAIL reset_wr: pwrite=%b pwdata=%h expected 0", pwrite, pwdata);
        end
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || psel !== 1'b0) begin
            errors++; $display("FAIL reset_idle: busy=%b psel=%b expected 0 with nothing pending", busy, psel);
        end
    endtask

    task automatic test_single_sweep;
        logic [63:0] exp;
        recs.delete(); busy_cycles = 0; addr_viol = 0;
        pulse(40'h1);
        wait_recs(NUM_CNT, 400, "single");
        checks++;
        if (recs.size() !== NUM_CNT) begin
            errors++; $display("FAIL single_count: got %0d records expected %0d", recs.size(), NUM_CNT);
        end
        for (int i = 0; i < recs.size() && i < NUM_CNT; i++) begin
            exp = {32'(2 * i + 1), 32'(2 * i)};
            checks++;
            if (recs[i].id !== 6'd0 || recs[i].index !== 5'(i) || recs[i].data !== exp ||
                recs[i].err !== 1'b0 || recs[i].last !== 1'(i == NUM_CNT - 1)) begin
                errors++;
                $display("FAIL single_rec%0d: id=%0d idx=%0d data=%h err=%b last=%b expected id=0 idx=%0d data=%h err=0 last=%b",
                         i, recs[i].id, recs[i].index, recs[i].data, recs[i].err, recs[i].last, i, exp, (i == NUM_CNT - 1));
            end
        end
        checks++;
        if (busy_cycles !== 130) begin
            errors++; $display("FAIL single_cycles: busy for %0d cycles expected 130", busy_cycles);
        end
        checks++;
        if (addr_viol !== 0) begin
            errors++; $display("FAIL single_paddr_stable: %0d violations expected 0", addr_viol);
        end
    endtask

    task automatic test_round_robin;
        int exp_id[4] = '{1, 2, 3, 1};
        int bad;
        recs.delete();
        pulse(40'h0A);
        repeat (20) @(negedge clk);
        pulse(40'h06);
        wait_recs(4 * NUM_CNT, 1200, "rr");
        checks++;
        if (recs.size() !== 4 * NUM_CNT) begin
            errors++; $display("FAIL rr_count: got %0d records expected %0d", recs.size(), 4 * NUM_CNT);
        end
        for (int s = 0; s < 4; s++) begin
            bad = 0;
            for (int j = 0; j < NUM_CNT; j++) begin
                if (s * NUM_CNT + j < recs.size()) begin
                    if (int'(recs[s * NUM_CNT + j].id) != exp_id[s] || int'(recs[s * NUM_CNT + j].index) != j) bad++;
                end else bad++;
            end
            checks++;
            if (bad !== 0) begin
                errors++; $display("FAIL rr_sweep%0d: %0d records wrong, expected channel %0d", s, bad, exp_id[s]);
            end
        end
    endtask

    task automatic test_hold_waits;
        int bad;
        recs.delete(); busy_cycles = 0; addr_viol = 0; hold_viol = 0; hold_cnt = 0;
        hold_idx = 5; hold_en = 1; hi_wait = 3;
        pulse(40'h1);
        wait_recs(NUM_CNT, 800, "hold");
        hold_en = 0; hi_wait = 0;
        bad = 0;
        for (int i = 0; i < recs.size(); i++)
            if (recs[i].id !== 6'd0 || recs[i].index !== 5'(i) ||
                recs[i].data !== {32'(2 * i + 1), 32'(2 * i)} || recs[i].err !== 1'b0) bad++;
        checks++;
        if (recs.size() !== NUM_CNT || bad !== 0) begin
            errors++; $display("FAIL hold_recs: %0d records, %0d wrong, expected %0d correct", recs.size(), bad, NUM_CNT);
        end
        checks++;
        if (hold_cnt !== 4 || hold_viol !== 0) begin
            errors++; $display("FAIL hold_stable: held %0d cycles with %0d changes, expected 4 and 0", hold_cnt, hold_viol);
        end
        checks++;
        if (addr_viol !== 0) begin
            errors++; $display("FAIL hold_paddr_stable: %0d violations expected 0", addr_viol);
        end
        checks++;
        if (busy_cycles !== 212) begin
            errors++; $display("FAIL hold_cycles: busy for %0d cycles expected 212", busy_cycles);
        end
    endtask

    task automatic test_slverr;
        int nerr;
        recs.delete();
        err_en = 1; err_idx = 7;
        pulse(40'h1);
        wait_recs(NUM_CNT, 400, "slverr");
        err_en = 0;
        nerr = 0;
        foreach (recs[i]) if (recs[i].err) nerr++;
        checks++;
        if (recs.size() !== NUM_CNT || recs[7].err !== 1'b1 || recs[7].data !== {32'd15, 32'd14}) begin
            errors++; $display("FAIL slverr_rec7: err=%b data=%h expected err=1 data=%h", recs[7].err, recs[7].data, {32'd15, 32'd14});
        end
        checks++;
        if (recs[8].err !== 1'b0 || nerr !== 1) begin
            errors++; $display("FAIL slverr_clear: rec8 err=%b total errs=%0d expected 0 and 1", recs[8].err, nerr);
        end
    endtask

    task automatic test_timeout;
`ifdef DCMAC_TX_STATS_POLL_TIMEOUT_EN
        recs.delete(); lo2_cnt = 0;
        stall_en = 1; stall_idx = 2;
        pulse(40'h1);
        wait_recs(NUM_CNT, 400, "tmo");
        stall_en = 0;
        checks++;
        if (recs.size() !== NUM_CNT || recs[NUM_CNT-1].last !== 1'b1) begin
            errors++; $display("FAIL tmo_complete: %0d records expected %0d ending with last", recs.size(), NUM_CNT);
        end
        checks++;
        if (recs[2].err !== 1'b1 || recs[2].data !== {32'd5, 32'd0}) begin
            errors++; $display("FAIL tmo_rec2: err=%b data=%h expected err=1 data=%h", recs[2].err, recs[2].data, {32'd5, 32'd0});
        end
        checks++;
        if (lo2_cnt !== TIMEOUT) begin
            errors++; $display("FAIL tmo_cycles: %0d access cycles expected %0d", lo2_cnt, TIMEOUT);
        end
        checks++;
        if (recs[3].err !== 1'b0 || recs[3].data !== {32'd7, 32'd6}) begin
            errors++; $display("FAIL tmo_rec3: err=%b data=%h expected err=0 data=%h", recs[3].err, recs[3].data, {32'd7, 32'd6});
        end
`else
        int k;
        recs.delete();
        stall_en = 1; stall_idx = 2;
        pulse(40'h1);
        k = 0;
        while (!(psel && penable && !paddr[0] && paddr[12:8] == 5'd2) && k < 100) begin
            @(negedge clk); k++;
        end
        repeat (40) @(negedge clk);
        checks++;
        if (psel !== 1'b1 || penable !== 1'b1 || paddr !== 32'h0000_0200) begin
            errors++; $display("FAIL stall_access: psel=%b penable=%b paddr=%h expected 1 1 00000200", psel, penable, paddr);
        end
        checks++;
        if (snap_valid !== 1'b0 || busy !== 1'b1 || recs.size() !== 2) begin
            errors++; $display("FAIL stall_hold: valid=%b busy=%b records=%0d expected 0 1 2", snap_valid, busy, recs.size());
        end
        stall_en = 0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid;
        int k, n;
        recs.delete();
        pulse(40'h1);
        pulse(40'h20);
        k = 0;
        while (!(psel && penable && paddr[0] && paddr[12:8] == 5'd3) && k < 300) begin
            @(negedge clk); k++;
        end
        checks++;
        if (k >= 300) begin
            errors++; $display("FAIL rstmid_wait: never reached index 3 high access");
        end
        n = recs.size();
        rstn = 1'b0;
        #1;
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || snap_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_async: psel=%b penable=%b valid=%b busy=%b expected 0", psel, penable, snap_valid, busy);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (n !== 3 || recs.size() !== 3) begin
            errors++; $display("FAIL rstmid_records: %0d before, %0d after reset, expected 3 and 3", n, recs.size());
        end
        checks++;
        if (busy !== 1'b0 || psel !== 1'b0) begin
            errors++; $display("FAIL rstmid_pend: busy=%b psel=%b expected 0 (pending channel 5 dropped)", busy, psel);
        end
    endtask

    initial begin
        test_reset();
        test_single_sweep();
        test_round_robin();
        test_hold_waits();
        test_slverr();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
